lsu_unit: RTL and testbench

Multi-cycle load/store unit downstream of the execute stage. Consumes the effective address, store data, funct3 (sb/sh/sw; lb/lh/lw/lbu/lhu) and rd from the decoder/ALU, and drives a single-port word-addressed data-memory bus with request/grant/response handshakes. It returns sign- or zero-extended load data to writeback and stalls the core via req_ready while busy.

---
 rtl/lsu_unit_if.sv | 53 +++++
 rtl/lsu_unit.sv | 177 +++++++++++++++++
 tb/tb_lsu_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_unit_if.sv
// Execute-side request/writeback and data-memory bus bundle for lsu_unit; slave = the unit, master = its environment.
// misalign_err exists only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic             req_is_store;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [TAG_W-1:0] req_rd;

    logic             done;
    logic             done_is_load;
    logic [TAG_W-1:0] done_rd;
    logic [XLEN-1:0]  done_data;

    logic             mem_req;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [3:0]       mem_wstrb;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic             misalign_err;
`endif

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output done, done_is_load, done_rd, done_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
        , output misalign_err
`endif
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  done, done_is_load, done_rd, done_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
        , input misalign_err
`endif
    );
endinterface

// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: accept -> done in 2 cycles (store) / 3 cycles (load) minimum; req_ready low while busy, mem_req held until mem_gnt.
// LSU_MISALIGN_TRAP_EN: misaligned ops complete immediately with misalign_err instead of being forced onto an aligned lane.
module lsu_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    lsu_unit_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT_R = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic [1:0]       r_state;
    logic             r_is_store;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic [XLEN-1:0]  r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic [XLEN-1:0]  r_done_data;
    logic [TAG_W-1:0] r_done_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    logic             r_misalign;
    logic             w_misalign;
`endif

    logic [1:0]       w_off;
    logic [1:0]       w_size;
    logic [1:0]       w_eff_off;
    logic [3:0]       w_strb;
    logic [XLEN-1:0]  w_lanes;
    logic [XLEN-1:0]  w_shifted;
    logic [XLEN-1:0]  w_load_data;

    assign w_off = bus.req_addr[1:0];

    // Unsupported funct3 codes fall through to a word access.
    always_comb begin
        w_size = SZ_W;
        if (bus.req_is_store) begin
            case (bus.req_funct3)
                3'b000:  w_size = SZ_B;
                3'b001:  w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000, 3'b100: w_size = SZ_B;
                3'b001, 3'b101: w_size = SZ_H;
                default:        w_size = SZ_W;
            endcase
        end
    end

    // Lane offset after forcing halves/words onto a naturally aligned lane.
    always_comb begin
        w_eff_off = 2'b00;
        w_strb    = 4'b1111;
        w_lanes   = bus.req_wdata;
        case (w_size)
            SZ_B: begin
                w_eff_off = w_off;
                w_strb    = 4'b0001 << w_off;
                w_lanes   = {(XLEN/8){bus.req_wdata[7:0]}};
            end
            SZ_H: begin
                w_eff_off = {w_off[1], 1'b0};
                w_strb    = 4'b0011 << {w_off[1], 1'b0};
                w_lanes   = {(XLEN/16){bus.req_wdata[15:0]}};
            end
            default: begin
                w_eff_off = 2'b00;
                w_strb    = 4'b1111;
                w_lanes   = bus.req_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_H) && w_off[0]) ||
                        ((w_size == SZ_W) && (w_off != 2'b00));
`endif

    assign w_shifted = bus.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_off       <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= 4'b0000;
            r_done_data <= '0;
            r_done_rd   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_is_store  <= bus.req_is_store;
                        r_funct3    <= bus.req_funct3;
                        r_off       <= w_eff_off;
                        r_mem_addr  <= {bus.req_addr[XLEN-1:2], 2'b00};
                        r_mem_wdata <= w_lanes;
                        r_mem_wstrb <= w_strb;
                        r_done_data <= '0;
                        r_done_rd   <= bus.req_rd;
`ifdef LSU_MISALIGN_TRAP_EN
                        r_misalign  <= w_misalign;
                        r_state     <= w_misalign ? ST_DONE : ST_REQ;
`else
                        r_state     <= ST_REQ;
`endif
                    end
                end
                // A simultaneous rvalid is deliberately ignored here: grant only.
                ST_REQ: begin
                    if (bus.mem_gnt) begin
                        r_state <= r_is_store ? ST_DONE : ST_WAIT_R;
                    end
                end
                ST_WAIT_R: begin
                    if (bus.mem_rvalid) begin
                        r_done_data <= w_load_data;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.mem_req   = (r_state == ST_REQ);
    assign bus.mem_we    = (r_state == ST_REQ) && r_is_store;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.done      = (r_state == ST_DONE);
    assign bus.done_rd   = r_done_rd;
    assign bus.done_data = r_done_data;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.done_is_load = (r_state == ST_DONE) && !r_is_store && !r_misalign;
    assign bus.misalign_err = (r_state == ST_DONE) && r_misalign;
`else
    assign bus.done_is_load = (r_state == ST_DONE) && !r_is_store;
`endif

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: expected completions queued at issue, popped and compared on each done pulse.
module tb_lsu_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

    lsu_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] data;
        int          lat;
        int          acc;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_is_load", {31'd0, bus.done_is_load}, {31'd0, e.is_load});
                chk("done_rd", {27'd0, bus.done_rd}, {27'd0, e.rd});
                chk("done_data", bus.done_data, e.data);
                chk("latency", cyc - e.acc, e.lat);
`ifdef LSU_MISALIGN_TRAP_EN
                chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.mis});
`endif
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_issue", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int gd, input int rv_dly, input logic [31:0] rdata, input logic both,
                         input logic [31:0] e_addr, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic [31:0] e_data);
        exp_t e;
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_rd       = rd;
        e.is_load = !st;
        e.rd      = rd;
        e.data    = e_data;
        e.lat     = st ? (2 + gd) : (3 + gd + rv_dly);
        e.acc     = cyc;
        e.mis     = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        // Keep a bogus request asserted while busy; it must be ignored.
        bus.req_addr = 32'h0000_0F00;
        bus.req_rd   = 5'd31;
        for (int i = 0; i <= gd; i++) begin
            @(negedge clk);
            chk("mem_req_held", {31'd0, bus.mem_req}, 32'd1);
            chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, st});
            chk("mem_addr", bus.mem_addr, e_addr);
            if (st) begin
                chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, e_strb});
                chk("mem_wdata", bus.mem_wdata, e_wdata);
            end
            if (i == gd) begin
                bus.mem_gnt   = 1'b1;
                bus.req_valid = 1'b0;
                if (both) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hBAD0_BAD0;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (!st) begin
            for (int i = 0; i <= rv_dly; i++) begin
                @(negedge clk);
                chk("mem_req_wait_r", {31'd0, bus.mem_req}, 32'd0);
                chk("req_ready_wait_r", {31'd0, bus.req_ready}, 32'd0);
                if (i == rv_dly) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rdata;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("ready_after_done", {31'd0, bus.req_ready}, 32'd1);
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic trap_op(input logic st, input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        exp_t e;
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = 32'h5555_AAAA;
        bus.req_rd       = rd;
        e.is_load = 1'b0;
        e.rd      = rd;
        e.data    = 32'h0;
        e.lat     = 1;
        e.acc     = cyc;
        e.mis     = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("trap_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        chk("trap_done", {31'd0, bus.done}, 32'd1);
        chk("trap_no_mem_req2", {31'd0, bus.mem_req}, 32'd0);
        @(negedge clk);
        chk("trap_done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_rd       = 5'd0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_done_is_load", {31'd0, bus.done_is_load}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h0);
        chk("rst_done_data", bus.done_data, 32'h0);
        chk("rst_done_rd", {27'd0, bus.done_rd}, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_misalign_err", {31'd0, bus.misalign_err}, 32'h0);
`endif
        rst = 1'b0;

        //     st    f3      addr          wdata         rd  gd rv rdata         both  e_addr        strb     e_wdata       e_data
        do_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 0, 0, 32'h0,         1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        do_op(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd2, 0, 0, 32'h0,         1'b0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        do_op(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 5'd3, 1, 0, 32'h0,         1'b0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0);
        do_op(1'b0, 3'b000, 32'h0000_0102, 32'h0,         5'd5, 0, 0, 32'h1280_FF00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_FF80);
        do_op(1'b0, 3'b100, 32'h0000_0102, 32'h0,         5'd7, 0, 0, 32'h1280_FF00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_0080);
        do_op(1'b0, 3'b001, 32'h0000_0102, 32'h0,         5'd9, 3, 2, 32'h8001_1234, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_8001);
        do_op(1'b0, 3'b101, 32'h0000_0100, 32'h0,         5'd10,0, 1, 32'h1234_8765, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_8765);
        do_op(1'b0, 3'b001, 32'h0000_0100, 32'h0,         5'd11,0, 0, 32'h1234_8765, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hFFFF_8765);
        do_op(1'b0, 3'b000, 32'h0000_0101, 32'h0,         5'd12,0, 0, 32'h0000_7F00, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_007F);
        do_op(1'b0, 3'b010, 32'h0000_0104, 32'h0,         5'd13,0, 1, 32'hCAFE_F00D, 1'b1, 32'h0000_0104, 4'b0000, 32'h0,         32'hCAFE_F00D);
        do_op(1'b1, 3'b100, 32'h0000_0108, 32'h0102_0304, 5'd14,2, 0, 32'h0,         1'b0, 32'h0000_0108, 4'b1111, 32'h0102_0304, 32'h0);
        do_op(1'b0, 3'b011, 32'h0000_010C, 32'h0,         5'd15,0, 0, 32'h89AB_CDEF, 1'b0, 32'h0000_010C, 4'b0000, 32'h0,         32'h89AB_CDEF);
        do_op(1'b0, 3'b110, 32'h0000_0110, 32'h0,         5'd16,1, 1, 32'h0BAD_F00D, 1'b0, 32'h0000_0110, 4'b0000, 32'h0,         32'h0BAD_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
        trap_op(1'b0, 3'b010, 32'h0000_0101, 5'd17);
        trap_op(1'b1, 3'b001, 32'h0000_0103, 5'd18);
        trap_op(1'b0, 3'b101, 32'h0000_0105, 5'd19);
`else
        do_op(1'b0, 3'b010, 32'h0000_0101, 32'h0,         5'd17,0, 0, 32'h1122_3344, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'h1122_3344);
        do_op(1'b0, 3'b001, 32'h0000_0103, 32'h0,         5'd18,0, 0, 32'h7FFF_0000, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'h0000_7FFF);
        do_op(1'b1, 3'b001, 32'h0000_0101, 32'h0000_5678, 5'd19,0, 0, 32'h0,         1'b0, 32'h0000_0100, 4'b0011, 32'h5678_5678, 32'h0);
`endif

        // Stray rvalid while idle must not complete anything.
        saved = done_cnt;
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rvalid_ignored", done_cnt, saved);

        // Reset while a load waits for its response.
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 32'h0000_0200;
        bus.req_rd       = 5'd20;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_r_ready_low", {31'd0, bus.req_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        saved = done_cnt;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h3333_4444;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_rvalid_no_done", done_cnt, saved);

        // Reset while a store is requesting the bus drops mem_req at once.
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 32'h0000_0300;
        bus.req_wdata    = 32'h7777_8888;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("req_before_rst", {31'd0, bus.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", done_cnt, saved);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
